// File: rtl/mm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mm_pkg
//  Purpose  : Shared types and constants for the 2x2 matrix MAC scheduler:
//             FSM state type, default widths and the fixed step-order table.
//  Revision : 1.0  initial release
// ============================================================================
package mm_pkg;

    localparam int MM_DW    = 8;
    localparam int MM_ACC_W = 2 * MM_DW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Operand/result indices used by one multiply-accumulate step
    typedef struct packed {
        logic [1:0] a_idx;
        logic [1:0] b_idx;
        logic [1:0] c_idx;
    } step_t;

    // Step k occupies bits [6k+5 : 6k] as {a_idx, b_idx, c_idx}.
    // Pairs (2m, 2m+1) together form C element m.
    localparam logic [47:0] STEP_TABLE = {
        6'b11_11_11,    // k7: A3*B3 -> c11
        6'b10_01_11,    // k6: A2*B1 -> c11
        6'b11_10_10,    // k5: A3*B2 -> c10
        6'b10_00_10,    // k4: A2*B0 -> c10
        6'b01_11_01,    // k3: A1*B3 -> c01
        6'b00_01_01,    // k2: A0*B1 -> c01
        6'b01_10_00,    // k1: A1*B2 -> c00
        6'b00_00_00     // k0: A0*B0 -> c00
    };

    function automatic step_t step_lookup(input logic [2:0] k);
        return step_t'(STEP_TABLE[int'(k) * 6 +: 6]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mm_mul_pipe
//  Purpose  : Unsigned DW x DW multiplier with MUL_LAT register stages; a
//             valid bit and 3-bit step tag travel alongside the product.
//             flush clears every in-flight valid bit.
//  Revision : 1.0  initial release
// ============================================================================
module mm_mul_pipe #(
    parameter int DW      = 8,
    parameter int MUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [2:0]      in_tag,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            out_valid,
    output logic [2:0]      out_tag,
    output logic [2*DW-1:0] prod
);

    logic [2*DW-1:0] mult;
    logic [2*DW-1:0] prod_q [MUL_LAT];
    logic [2:0]      tag_q  [MUL_LAT];
    logic [MUL_LAT-1:0] valid_q;

    assign mult = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // Shift product, tag and valid through the pipeline; flush kills valids
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid & ~flush;
            prod_q[0]  <= mult;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                valid_q[i] <= valid_q[i-1] & ~flush;
                prod_q[i]  <= prod_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[MUL_LAT-1];
    assign out_tag   = tag_q[MUL_LAT-1];
    assign prod      = prod_q[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/mm2x2_mac_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mm2x2_mac_scheduler
//  Purpose  : Computes C = A x B (2x2, unsigned) with one shared pipelined
//             multiplier: 8 MAC steps in fixed order, start/busy/done
//             handshake, synchronous abort.
//  Revision : 1.0  initial release
// ============================================================================
module mm2x2_mac_scheduler
    import mm_pkg::*;
#(
    parameter int DW      = MM_DW,
    parameter int ACC_W   = 2 * DW + 1,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [4*DW-1:0]  a_flat,
    input  logic [4*DW-1:0]  b_flat,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             start_dropped,
    output logic [ACC_W-1:0] c00,
    output logic [ACC_W-1:0] c01,
    output logic [ACC_W-1:0] c10,
    output logic [ACC_W-1:0] c11
);

    state_t           state;
    state_t           state_nxt;
    logic [4*DW-1:0]  a_snap;
    logic [4*DW-1:0]  b_snap;
    logic [2:0]       step_k;
    logic [2*DW-1:0]  acc;

    logic             accept;
    logic             drop;
    logic             issue_valid;
    logic             last_acc;

    step_t            issue_step;
    step_t            result_step;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic             pipe_valid;
    logic [2:0]       pipe_tag;
    logic [2*DW-1:0]  pipe_prod;
    logic [ACC_W-1:0] pair_sum;
    logic             unused_fields;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)        state_nxt = ISSUE;
                ISSUE:   if (step_k == 3'd7) state_nxt = DRAIN;
                DRAIN:   if (last_acc)      state_nxt = IDLE;
                default:                    state_nxt = IDLE;
            endcase
        end
    end

    // Control strobes; busy stays high through the done cycle, so a start
    // arriving there counts as dropped rather than accepted
    always_comb begin
        accept      = 1'b0;
        drop        = 1'b0;
        issue_valid = 1'b0;
        last_acc    = 1'b0;
        if (!abort) begin
            accept      = (state == IDLE) && !busy && start;
            drop        = start && busy;
            issue_valid = (state == ISSUE);
            last_acc    = pipe_valid && (pipe_tag == 3'd7);
        end
    end

    assign issue_step  = step_lookup(step_k);
    assign result_step = step_lookup(pipe_tag);
    assign op_a        = a_snap[issue_step.a_idx * DW +: DW];
    assign op_b        = b_snap[issue_step.b_idx * DW +: DW];
    assign pair_sum    = ACC_W'(acc) + ACC_W'(pipe_prod);
    assign unused_fields = ^{issue_step.c_idx, result_step.a_idx, result_step.b_idx};

    mm_mul_pipe #(
        .DW      (DW),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (issue_valid),
        .in_tag    (step_k),
        .a         (op_a),
        .b         (op_b),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .prod      (pipe_prod)
    );

    // Operand snapshot on acceptance and step counter during ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_snap <= '0;
            b_snap <= '0;
            step_k <= '0;
        end else if (abort) begin
            step_k <= '0;
        end else if (accept) begin
            a_snap <= a_flat;
            b_snap <= b_flat;
            step_k <= '0;
        end else if (issue_valid) begin
            step_k <= step_k + 3'd1;
        end
    end

    // Even steps load the partial product, odd steps finish one C element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            c00 <= '0;
            c01 <= '0;
            c10 <= '0;
            c11 <= '0;
        end else if (pipe_valid && !abort) begin
            if (!pipe_tag[0]) begin
                acc <= pipe_prod;
            end else begin
                case (result_step.c_idx)
                    2'd0:    c00 <= pair_sum;
                    2'd1:    c01 <= pair_sum;
                    2'd2:    c10 <= pair_sum;
                    default: c11 <= pair_sum;
                endcase
            end
        end
    end

    // Handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            result_valid  <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            done          <= last_acc;
            start_dropped <= drop;
            if (abort) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (accept) begin
                result_valid <= 1'b0;
            end else if (last_acc) begin
                result_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
